// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: state encoding and default widths shared by the serial pattern generator
package seq_gen_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;
    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: parallel-load MSB-first shift register with first/last bit flags
module seq_gen_shreg import seq_gen_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             restart,
    input  logic             step,
    input  logic [PAT_W-1:0] pattern,
    output logic             msb,
    output logic             first_bit,
    output logic             last_bit
);
    localparam int IW = $clog2(PAT_W);
    logic [PAT_W-1:0] pat, sh;
    logic [IW-1:0] idx;
    // pat keeps the loaded pattern so every repetition can reload sh from it
    always_ff @(posedge clk) begin
        if (rst) begin
            pat <= '0;
            sh  <= '0;
            idx <= IW'(PAT_W-1);
        end else if (load) begin
            pat <= pattern;
            sh  <= pattern;
            idx <= IW'(PAT_W-1);
        end else if (restart) begin
            sh  <= pat;
            idx <= IW'(PAT_W-1);
        end else if (step) begin
            sh  <= {sh[PAT_W-2:0], 1'b0};
            idx <= idx - IW'(1);
        end
    end
    assign msb       = sh[PAT_W-1];
    assign first_bit = idx == IW'(PAT_W-1);
    assign last_bit  = idx == '0;
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: programmable serial bit-pattern generator with repeat count and inter-frame gap
module seq_pattern_gen import seq_gen_pkg::*; #(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] load_pattern,
    input  logic [CNT_W-1:0] load_repeat,
    input  logic [CNT_W-1:0] load_gap,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);
    state_t state;
    logic [CNT_W-1:0] reps, gap, gap_cnt;
    logic accept, more, restart, step, msb, first_bit, last_bit;
    assign accept  = state == IDLE && load_valid && !abort;
    assign more    = reps != CNT_W'(1);
    // a new repetition starts straight from the last bit when gap is zero, else at the end of GAP
    assign restart = (state == SHIFT && last_bit && more && gap == '0) ||
                     (state == GAP && gap_cnt == CNT_W'(1));
    assign step    = state == SHIFT && !last_bit;
    seq_gen_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .restart   (restart),
        .step      (step),
        .pattern   (load_pattern),
        .msb       (msb),
        .first_bit (first_bit),
        .last_bit  (last_bit)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            reps    <= '0;
            gap     <= '0;
            gap_cnt <= '0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    reps  <= load_repeat;
                    gap   <= load_gap;
                    state <= load_repeat == '0 ? DONE : SHIFT;
                end
                SHIFT: if (last_bit) begin
                    reps    <= reps - CNT_W'(1);
                    gap_cnt <= gap;
                    state   <= !more ? DONE : gap == '0 ? SHIFT : GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - CNT_W'(1);
                    if (gap_cnt == CNT_W'(1)) state <= SHIFT;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
    // outputs are pure decodes of registered state and shift-register contents
    assign ser_valid   = state == SHIFT;
    assign ser_out     = ser_valid && msb;
    assign frame_start = ser_valid && first_bit;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    assign load_ready  = state == IDLE;
endmodule
